io_bus_ctrl: RTL and testbench

Memory-mapped I/O controller directly downstream of the single-cycle CPU's data port. It decodes the CPU's `m_addr`/`m_read`/`m_write`/`d_t_mem` into either data-memory accesses or I/O register accesses, and returns `d_f_mem` combinationally in the same cycle. The I/O space holds:

- an 8-deep keyboard scan-code FIFO;
- an LED output register;
- a prescaled free-running timer.

---
 rtl/io_map_pkg.sv | 19 +
 rtl/kbd_fifo.sv | 73 +++++++
 rtl/io_bus_ctrl.sv | 126 ++++++++++++
 tb/tb_io_bus_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// io_map_pkg: the address map shared by the I/O controller and its sub-blocks.
//   IO_NIBBLE_DEFAULT : m_addr[31:28] value that selects I/O space.
//   OFS_*             : register word index, i.e. m_addr[4:2] (byte offset / 4).
//   ST_*              : bit positions inside the STATUS register.
package io_map_pkg;

   localparam logic [3:0] IO_NIBBLE_DEFAULT = 4'hA;

   // Byte offsets 0x00/0x04/0x08/0x0C expressed as word indices.
   localparam logic [2:0] OFS_STATUS = 3'd0;
   localparam logic [2:0] OFS_KBD    = 3'd1;
   localparam logic [2:0] OFS_LED    = 3'd2;
   localparam logic [2:0] OFS_TIMER  = 3'd3;

   localparam int ST_NONEMPTY = 0;
   localparam int ST_OVF      = 2;
   localparam int ST_FULL     = 3;

endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: synchronous scan-code FIFO.
//   clk, clr   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and byte; dropped when full unless popped too
//   pop        : read request; ignored when empty
//   dout       : head entry (meaningless while empty)
//   full, empty: occupancy flags
module kbd_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      // A pop frees the slot the push needs, so push+pop while full both proceed.
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count alone decides what is visible.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped I/O decode for the CPU data port.
//   clk, clr        : clock, synchronous active-high reset
//   m_addr          : CPU byte address; [31:28]==IO_NIBBLE selects I/O space
//   m_read, m_write : single-cycle load/store strobes
//   d_t_mem         : store data
//   d_f_mem         : load data, combinational in the same cycle
//   dmem_rdata      : data RAM read data
//   dmem_we         : data RAM write enable (stores outside I/O space)
//   kbd_data/valid  : scan-code byte and its one-cycle strobe
//   led_out         : LED register
// Handshake: m_read/m_write and kbd_valid are valid-only strobes with no
// ready; every access completes in the cycle it is presented, so one load
// of KBD_DATA pops exactly one entry and a push to a full FIFO is dropped.
module io_bus_ctrl
   import io_map_pkg::*;
#(
   parameter int         FIFO_DEPTH = 8,
   parameter int         TICK_DIV   = 50000,
   parameter logic [3:0] IO_NIBBLE  = IO_NIBBLE_DEFAULT
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] m_addr,
   input  logic        m_read,
   input  logic        m_write,
   input  logic [31:0] d_t_mem,
   output logic [31:0] d_f_mem,
   input  logic [31:0] dmem_rdata,
   output logic        dmem_we,
   input  logic [7:0]  kbd_data,
   input  logic        kbd_valid,
   output logic [15:0] led_out
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   logic        io_sel;
   logic [2:0]  reg_sel;
   logic        wr_status, wr_led, wr_timer, rd_kbd;
   logic        fifo_full, fifo_empty;
   logic [7:0]  fifo_head;
   logic [31:0] status_w;
   logic        tick;
   logic        unused_addr_bits;

   logic          ovf_q, ovf_d;
   logic [15:0]   led_q, led_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [31:0]   cnt_q, cnt_d;

   assign io_sel    = (m_addr[31:28] == IO_NIBBLE);
   assign reg_sel   = m_addr[4:2];
   assign dmem_we   = m_write & ~io_sel;
   assign wr_status = m_write & io_sel & (reg_sel == OFS_STATUS);
   assign wr_led    = m_write & io_sel & (reg_sel == OFS_LED);
   assign wr_timer  = m_write & io_sel & (reg_sel == OFS_TIMER);
   assign rd_kbd    = m_read  & io_sel & (reg_sel == OFS_KBD);
   assign led_out   = led_q;
   assign tick      = (presc_q == PRESC_MAX);
   assign unused_addr_bits = ^{m_addr[27:5], m_addr[1:0]};

   kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (kbd_valid),
      .din   (kbd_data),
      .pop   (rd_kbd),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      status_w              = '0;
      status_w[ST_NONEMPTY] = ~fifo_empty;
      status_w[ST_OVF]      = ovf_q;
      status_w[ST_FULL]     = fifo_full;
   end

   always_comb begin
      d_f_mem = '0;
      if (!io_sel) begin
         d_f_mem = dmem_rdata;
      end else begin
         case (reg_sel)
            OFS_STATUS: d_f_mem = status_w;
            OFS_KBD:    d_f_mem = fifo_empty ? 32'd0 : {24'd0, fifo_head};
            OFS_LED:    d_f_mem = {16'd0, led_q};
            OFS_TIMER:  d_f_mem = cnt_q;
            default:    d_f_mem = '0;
         endcase
      end
   end

   always_comb begin
      // Drop-on-full is flagged after the clear so a same-cycle set wins.
      ovf_d = ovf_q;
      if (wr_status) ovf_d = 1'b0;
      if (kbd_valid & fifo_full & ~rd_kbd) ovf_d = 1'b1;

      led_d = wr_led ? d_t_mem[15:0] : led_q;

      presc_d = tick ? '0 : presc_q + 1'b1;
      cnt_d   = tick ? cnt_q + 32'd1 : cnt_q;
      if (wr_timer) begin
         presc_d = '0;
         cnt_d   = d_t_mem;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         ovf_q   <= 1'b0;
         led_q   <= '0;
         presc_q <= '0;
         cnt_q   <= '0;
      end else begin
         ovf_q   <= ovf_d;
         led_q   <= led_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_io_bus_ctrl.sv
module tb_io_bus_ctrl;

   localparam logic [31:0] A_STATUS = 32'hA000_0000;
   localparam logic [31:0] A_KBD    = 32'hA000_0004;
   localparam logic [31:0] A_LED    = 32'hA000_0008;
   localparam logic [31:0] A_TIMER  = 32'hA000_000C;
   localparam logic [31:0] A_UNMAP  = 32'hA000_0014;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [31:0] m_addr = '0;
   logic        m_read = 1'b0;
   logic        m_write = 1'b0;
   logic [31:0] d_t_mem = '0;
   logic [31:0] d_f_mem;
   logic [31:0] dmem_rdata = 32'hDEAD_BEEF;
   logic        dmem_we;
   logic [7:0]  kbd_data = '0;
   logic        kbd_valid = 1'b0;
   logic [15:0] led_out;

   logic [31:0] exp_q[$];
   string       name_q[$];
   int          checks = 0;
   int          errors = 0;

   io_bus_ctrl #(.FIFO_DEPTH(8), .TICK_DIV(4), .IO_NIBBLE(4'hA)) dut (
      .clk        (clk),
      .clr        (clr),
      .m_addr     (m_addr),
      .m_read     (m_read),
      .m_write    (m_write),
      .d_t_mem    (d_t_mem),
      .d_f_mem    (d_f_mem),
      .dmem_rdata (dmem_rdata),
      .dmem_we    (dmem_we),
      .kbd_data   (kbd_data),
      .kbd_valid  (kbd_valid),
      .led_out    (led_out)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // scoreboard monitor: every CPU load is compared against the queue
   always @(negedge clk) begin
      if (m_read && !clr) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: got 0x%08h expected no read", d_f_mem);
         end else begin
            chk(name_q.pop_front(), d_f_mem, exp_q.pop_front());
         end
      end
   end

   // driver tasks: each starts and ends 1 time unit after a rising edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
      m_addr = a;
      m_read = 1'b1;
      step(1);
      m_read = 1'b0;
      m_addr = '0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic exp_we,
                            input string nm);
      m_addr  = a;
      d_t_mem = d;
      m_write = 1'b1;
      #1;
      chk(nm, {31'd0, dmem_we}, {31'd0, exp_we});
      step(1);
      m_write = 1'b0;
      m_addr  = '0;
   endtask

   task automatic kbd_push(input logic [7:0] b);
      kbd_data  = b;
      kbd_valid = 1'b1;
      step(1);
      kbd_valid = 1'b0;
   endtask

   task automatic push_and_read(input logic [7:0] b, input logic [31:0] e, input string nm);
      kbd_data  = b;
      kbd_valid = 1'b1;
      bus_read(A_KBD, e, nm);
      kbd_valid = 1'b0;
   endtask

   initial begin
      clr = 1'b1;
      step(2);
      chk("led_in_reset", {16'd0, led_out}, 32'd0);
      clr = 1'b0;

      // reset state; TIMER read lands before the first tick (edge 4)
      bus_read(A_STATUS, 32'h0, "rst_status");
      bus_read(A_KBD,    32'h0, "rst_kbd");
      bus_read(A_LED,    32'h0, "rst_led");
      bus_read(A_TIMER,  32'h0, "rst_timer");

      // 12 edges after reset -> 3 ticks of 4
      step(8);
      bus_read(A_TIMER, 32'd3, "timer_12cyc");
      bus_write(A_TIMER, 32'hFFFF_FFFF, 1'b0, "timer_wr_we");
      bus_read(A_TIMER, 32'hFFFF_FFFF, "timer_loaded");
      step(3);
      bus_read(A_TIMER, 32'h0, "timer_wrap");

      // basic FIFO ordering
      kbd_push(8'h1C);
      kbd_push(8'h32);
      bus_read(A_STATUS, 32'h1, "st_nonempty");
      bus_read(A_KBD, 32'h1C, "kbd_first");
      bus_read(A_KBD, 32'h32, "kbd_second");
      bus_read(A_STATUS, 32'h0, "st_drained");

      // overflow: 9 pushes into 8 entries
      for (int i = 1; i <= 9; i++) kbd_push(8'(i));
      bus_read(A_STATUS, 32'hD, "st_full_ovf");
      bus_write(A_KBD, 32'h55, 1'b0, "kbd_wr_we");
      for (int i = 1; i <= 8; i++) bus_read(A_KBD, 32'(i), "kbd_ovf_seq");
      bus_read(A_KBD, 32'h0, "kbd_empty");
      bus_read(A_STATUS, 32'h4, "st_ovf_only");
      bus_write(A_STATUS, 32'h0, 1'b0, "st_wr_we");
      bus_read(A_STATUS, 32'h0, "st_ovf_clr");

      // full FIFO: push and pop in the same cycle
      for (int i = 0; i < 8; i++) kbd_push(8'(8'h11 + i));
      push_and_read(8'hAA, 32'h11, "full_push_pop");
      bus_read(A_STATUS, 32'h9, "st_full_noovf");
      for (int i = 1; i < 8; i++) bus_read(A_KBD, 32'(8'h11 + i), "kbd_full_seq");
      bus_read(A_KBD, 32'hAA, "kbd_last_aa");
      bus_read(A_STATUS, 32'h0, "st_after_full");

      // empty FIFO: push and pop in the same cycle -> read 0, push kept
      push_and_read(8'h5A, 32'h0, "empty_push_pop");
      bus_read(A_KBD, 32'h5A, "kbd_kept_5a");

      // LED, decode, data-memory path, unmapped space
      bus_write(A_LED, 32'h0000_ABCD, 1'b0, "led_wr_we");
      chk("led_out_abcd", {16'd0, led_out}, 32'h0000_ABCD);
      bus_write(32'h0000_0008, 32'h0000_1234, 1'b1, "dmem_wr_we");
      chk("led_unchanged", {16'd0, led_out}, 32'h0000_ABCD);
      bus_read(32'hA000_0FEB, 32'h0000_ABCD, "led_alias");
      bus_read(32'h0000_0100, 32'hDEAD_BEEF, "dmem_read");
      bus_write(A_UNMAP, 32'hFFFF_FFFF, 1'b0, "unmap_wr_we");
      bus_read(A_UNMAP, 32'h0, "unmap_read");

      // reset mid-operation discards contents and a same-cycle push
      kbd_push(8'h77);
      clr       = 1'b1;
      kbd_data  = 8'h66;
      kbd_valid = 1'b1;
      step(1);
      clr       = 1'b0;
      kbd_valid = 1'b0;
      chk("led_after_clr", {16'd0, led_out}, 32'h0);
      bus_read(A_STATUS, 32'h0, "st_after_clr");
      bus_read(A_KBD, 32'h0, "kbd_after_clr");

      step(2);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL timeout: got no end of test expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
